// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, instruction
// field positions, sequencer states and data width.
package cpu_pkg;

  localparam int unsigned DataW    = 16;
  localparam int unsigned InstrW   = 18;
  localparam int unsigned RegAddrW = 3;
  localparam int unsigned ImmW     = 9;

  localparam int unsigned OpMsb  = 17;
  localparam int unsigned OpLsb  = 15;
  localparam int unsigned RdMsb  = 14;
  localparam int unsigned RdLsb  = 12;
  localparam int unsigned Rs1Msb = 11;
  localparam int unsigned Rs1Lsb = 9;
  localparam int unsigned Rs2Msb = 8;
  localparam int unsigned Rs2Lsb = 6;
  localparam int unsigned ImmMsb = 8;
  localparam int unsigned ImmLsb = 0;

  typedef enum logic [2:0] {
    OpLoad    = 3'd0,
    OpAdd     = 3'd1,
    OpAddi    = 3'd2,
    OpSub     = 3'd3,
    OpSubi    = 3'd4,
    OpMul     = 3'd5,
    OpClear   = 3'd6,
    OpDisplay = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDecode = 2'd1,
    StExec   = 2'd2,
    StWb     = 2'd3
  } state_e;

  function automatic logic [DataW-1:0] sext_imm(input logic [ImmW-1:0] imm);
    return {{(DataW - ImmW){imm[ImmW-1]}}, imm};
  endfunction

endpackage

// File: rtl/module_control_unit_if.sv
// Instruction handshake, ALU operand/result and display signals of the
// control unit; slave is the control unit's view, master the environment's.
interface module_control_unit_if;
  import cpu_pkg::*;

  logic              instr_valid;
  logic [InstrW-1:0] instr;
  logic              instr_ready;
  logic [2:0]        alu_op;
  logic [DataW-1:0]  alu_a;
  logic [DataW-1:0]  alu_b;
  logic [DataW-1:0]  alu_result;
  logic              busy;
  logic              done;
  logic              disp_valid;
  logic [DataW-1:0]  disp_value;

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_op, alu_a, alu_b, busy, done, disp_valid, disp_value
  );

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_op, alu_a, alu_b, busy, done, disp_valid, disp_value
  );

endinterface

// File: rtl/module_regfile.sv
// General register file: two asynchronous read ports, one synchronous write
// port and a synchronous clear-all that takes priority over the write.
module module_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned NRegs = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RegAddrW-1:0] raddr_a_i,
  output logic [DataW-1:0]    rdata_a_o,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic [DataW-1:0]    rdata_b_o,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [DataW-1:0]    wdata_i,
  input  logic                clear_i
);

  logic [DataW-1:0] regs_q [NRegs];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRegs; i++) regs_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NRegs; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/module_control_unit.sv
// Multi-cycle sequencer: accepts one instruction, drives the external ALU,
// and writes results back into the register file it owns.
module module_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned NREGS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  module_control_unit_if.slave  bus
);

  state_e            state_q, state_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DataW-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [DataW-1:0]  result_q, result_d;
  logic [DataW-1:0]  disp_value_q, disp_value_d;
  logic [2:0]        cnt_q, cnt_d;

  opcode_e          op;
  logic [DataW-1:0] imm_ext, rdata_a, rdata_b, rf_wdata;
  logic             rf_we, rf_clear;

  assign op      = opcode_e'(instr_q[OpMsb:OpLsb]);
  assign imm_ext = sext_imm(instr_q[ImmMsb:ImmLsb]);

  module_regfile #(
    .NRegs (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a_i (instr_q[Rs1Msb:Rs1Lsb]),
    .rdata_a_o (rdata_a),
    .raddr_b_i (instr_q[Rs2Msb:Rs2Lsb]),
    .rdata_b_o (rdata_b),
    .we_i      (rf_we),
    .waddr_i   (instr_q[RdMsb:RdLsb]),
    .wdata_i   (rf_wdata),
    .clear_i   (rf_clear)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    result_d     = result_q;
    disp_value_d = disp_value_q;
    cnt_d        = cnt_q;
    rf_we        = 1'b0;
    rf_clear     = 1'b0;
    rf_wdata     = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        alu_op_d = instr_q[OpMsb:OpLsb];
        unique case (op)
          OpAdd, OpSub, OpMul, OpAddi, OpSubi: begin
            alu_a_d = rdata_a;
            alu_b_d = (op == OpAddi || op == OpSubi) ? imm_ext : rdata_b;
            cnt_d   = (op == OpMul) ? 3'(MUL_LAT) : 3'd1;
            state_d = StExec;
          end
          default: state_d = StWb;
        endcase
      end
      StExec: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          result_d = bus.alu_result;
          state_d  = StWb;
        end
      end
      StWb: begin
        state_d = StIdle;
        unique case (op)
          OpLoad: begin
            rf_we    = 1'b1;
            rf_wdata = imm_ext;
          end
          OpClear:   rf_clear     = 1'b1;
          OpDisplay: disp_value_d = rdata_a;
          default:   rf_we        = 1'b1;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
      disp_value_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      result_q     <= result_d;
      disp_value_q <= disp_value_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StWb);
  assign bus.disp_valid  = (state_q == StWb) && (op == OpDisplay);
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.disp_value  = disp_value_q;

endmodule

// File: doc/module_control_unit.md
Name: module_control_unit

Overview:
- Multi-cycle sequencer for the 16-bit CPU datapath. Accepts one instruction at a time over a valid/ready handshake.
- Owns the 8x16 general register file. Drives the external combinational ALU's opcode and operands, captures its result and writes it back.
- Executes LOAD, CLEAR and DISPLAY itself; these do not use the ALU.
- Sits between the instruction source (program ROM/switch front-end) and the ALU/display.

Parameters:
- MUL_LAT, 2, cycles spent in EXEC for MUL (legal range 1..7); all other ALU ops spend 1 cycle.
- NREGS, 8, number of general registers (fixed at 8; index width 3).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present on instr
- instr  in  18  [17:15] opcode, [14:12] rd, [11:9] rs1, [8:6] rs2, [8:0] imm9 (signed; overlaps rs2)
- instr_ready  out  1  high only in IDLE
- alu_op  out  3  opcode to ALU (LOAD=0 ADD=1 ADDI=2 SUB=3 SUBI=4 MUL=5 CLEAR=6 DISPLAY=7)
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_result  in  16  combinational ALU result, already saturated
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in the WB cycle
- disp_valid  out  1  one-cycle pulse in WB of DISPLAY
- disp_value  out  16  last displayed register value, held until next DISPLAY

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all registers R0..R7=0; alu_op/alu_a/alu_b=0; done=disp_valid=0; disp_value=0; MUL counter=0.
  - Reset mid-instruction aborts the instruction: no write-back, no done pulse.
- States: IDLE -> DECODE -> [EXEC] -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On the edge where instr_valid&instr_ready, latch instr and go to DECODE.
  - instr is ignored outside IDLE; the source may change it freely while busy.
- DECODE (1 cycle):
  - Register alu_op=opcode and alu_a=R[rs1].
  - alu_b=R[rs2] for ADD/SUB/MUL; alu_b=sign-extended imm9 for ADDI/SUBI.
  - ALU ops go to EXEC. LOAD/CLEAR/DISPLAY go directly to WB; alu_a/alu_b are left unchanged and alu_op=opcode.
- EXEC:
  - Operands are held stable.
  - The counter loads 1 (non-MUL) or MUL_LAT (MUL) on entry and decrements each cycle.
  - On the last EXEC cycle, capture alu_result into result_q and go to WB.
- WB (1 cycle), done=1:
  - ALU ops: R[rd] <= result_q.
  - LOAD: R[rd] <= sext(imm9).
  - CLEAR: all 8 registers <= 0 (rd ignored).
  - DISPLAY: disp_value <= R[rs1] and disp_valid=1.
  - Next state is IDLE.
- Latency, with T = accept edge:
  - done high in cycle T+2 for LOAD/CLEAR/DISPLAY.
  - done high in cycle T+3 for ADD/ADDI/SUB/SUBI.
  - done high in cycle T+2+MUL_LAT for MUL.
  - instr_ready returns the cycle after done.
- Hazards: none. Write-back completes before the next accept, so a following instruction always reads the updated rd. R0 is an ordinary writable register; rd==rs1 is legal.
- Width rules:
  - imm9 is sign-extended to 16 bits (range -256..255).
  - Saturation is performed by the ALU; the controller does not modify alu_result.
- instr_valid held high continuously: instructions are accepted back-to-back, one accept per instruction length + 1 cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (LOAD..DISPLAY);
  - instruction field positions and widths (OP_MSB/LSB, RD, RS1, RS2, IMM);
  - the state encoding (IDLE, DECODE, EXEC, WB);
  - the data width 16.
- Sub-module module_regfile:
  - 8x16, two asynchronous read ports, one synchronous write port, synchronous clear-all input;
  - asynchronous active-low reset to zero.
- The ALU is instantiated at the CPU top level, not inside this block.

Test Plan:
- Reset, then LOAD R1,#5 -> done at T+2. Then DISPLAY R1 -> disp_value=0x0005 with disp_valid high exactly 1 cycle.
- LOAD R2,#-3; ADD R3,R1,R2 -> in EXEC alu_op=1, alu_a=0x0005, alu_b=0xFFFD. done at T+3. DISPLAY R3 -> 0x0002.
- ADDI R4,R1,#255 -> R4=0x0104. SUBI R5,R1,#-256 -> alu_b=0xFF00 and R5=0x0105, confirming sign extension.
- LOAD R1,#200; LOAD R2,#200; MUL R6,R1,R2 with MUL_LAT=2 -> done at T+4 and R6=0x7FFF (ALU saturation). instr_valid held high throughout, with next accept only at T+5.
- CLEAR, then DISPLAY R3 and DISPLAY R6 -> both 0x0000; done for CLEAR at T+2.
- Pull rst_n low during EXEC of ADD R7,R1,R2 -> immediately state=IDLE and all outputs 0. After release, no done pulse; DISPLAY R7 -> 0x0000.
